// File: rtl/fp_pow_pkg.sv
// Shared constants and FSM state encoding for the integer-power unit.
package fp_pow_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_E    = 32'h402D_F854;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MUL   = 3'd2,
    SQ    = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fp_int_power_if.sv
// Start/valid/busy request bundle between the ALU issue logic and fp_int_power.
interface fp_int_power_if #(
  parameter int EXP_W = 16
);
  logic             start;
  logic             use_e;
  logic [31:0]      base;
  logic [EXP_W-1:0] exp;
  logic [31:0]      result;
  logic             valid;
  logic             busy;

  modport master (output start, use_e, base, exp, input result, valid, busy);
  modport slave  (input start, use_e, base, exp, output result, valid, busy);
endinterface

// File: rtl/fp_pow_special.sv
// Combinational classifier for bases whose integer power is known without
// multiplying: NaN, signed zero, signed one and signed infinity.
// Only instantiated when FP_POW_SPECIAL_EN is defined.
module fp_pow_special
  import fp_pow_pkg::*;
(
  input  logic [31:0] base,
  input  logic        odd,
  output logic        is_special,
  output logic [31:0] forced
);

  logic [31:0] sign_s;

  // Map the base class to its forced power; the sign survives only for odd exponents.
  always_comb begin
    sign_s     = {base[31] & odd, 31'h0};
    is_special = 1'b1;
    forced     = FP_ONE;
    if ((base[30:23] == 8'hFF) && (base[22:0] != 23'h0)) begin
      forced = FP_QNAN;
    end else if (base[30:0] == 31'h0) begin
      forced = sign_s;
    end else if (base[30:0] == FP_ONE[30:0]) begin
      forced = FP_ONE | sign_s;
    end else if (base[30:0] == FP_PINF[30:0]) begin
      forced = FP_PINF | sign_s;
    end else begin
      is_special = 1'b0;
      forced     = FP_ONE;
    end
  end

endmodule

// File: rtl/ieee_754_multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier, round to nearest even.
// Subnormal inputs are treated as zero and underflow flushes to signed zero.
// Operands are captured on start; valid pulses LAT edges later.
module ieee_754_multiplier #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        valid,
  output logic        busy
);

  logic [31:0] a_r, b_r;
  logic [3:0]  cnt_r;

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic              sgn, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, g, s, inc;
    logic [47:0]       p;
    logic [22:0]       m;
    logic [23:0]       sum;
    logic signed [9:0] e;
    logic [31:0]       r;
    sgn    = x[31] ^ y[31];
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    x_inf  = (x[30:0] == 31'h7F80_0000);
    y_inf  = (y[30:0] == 31'h7F80_0000);
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    p = {24'h0, 1'b1, x[22:0]} * {24'h0, 1'b1, y[22:0]};
    e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; s = |p[22:0]; e = e + 10'sd1;
    end else begin
      m = p[45:23]; g = p[22]; s = |p[21:0];
    end
    inc = g & (s | m[0]);
    sum = {1'b0, m} + {23'h0, inc};
    if (sum[23]) begin
      e = e + 10'sd1;
    end
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
      r = 32'h7FC0_0000;
    end else if (x_inf || y_inf || (e > 10'sd254)) begin
      r = {sgn, 31'h7F80_0000};
    end else if (x_zero || y_zero || (e < 10'sd1)) begin
      r = {sgn, 31'h0};
    end else begin
      r = {sgn, e[7:0], sum[22:0]};
    end
    return r;
  endfunction

  // Capture operands on start, count down the latency, then publish the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= 32'h0;
      b_r    <= 32'h0;
      cnt_r  <= 4'd0;
      result <= 32'h0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start && !busy) begin
        a_r   <= a;
        b_r   <= b;
        cnt_r <= 4'(LAT - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        if (cnt_r == 4'd0) begin
          result <= fmul(a_r, b_r);
          valid  <= 1'b1;
          busy   <= 1'b0;
        end else begin
          cnt_r <= cnt_r - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/fp_int_power.sv
// Single-precision base^exp for an unsigned integer exponent using
// right-to-left square-and-multiply on one shared multiplier.
// Optional feature macro: FP_POW_SPECIAL_EN (short-circuit NaN/0/1/inf bases).
module fp_int_power
  import fp_pow_pkg::*;
#(
  parameter int EXP_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  fp_int_power_if.slave  bus
);

  state_t           state_r;
  logic [31:0]      acc_r, sq_r, result_r, dec_forced_r;
  logic [EXP_W-1:0] e_rem_r;
  logic             ph_r, valid_r, busy_r, mult_start_r, dec_zero_r, dec_spec_r;
  logic             spec_s;
  logic [31:0]      forced_s, mult_a_s, mult_res_s;
  logic             mult_valid_s, mult_busy_s;

`ifdef FP_POW_SPECIAL_EN
  logic [31:0] base_r;
  logic        odd_r;

  fp_pow_special u_special (
    .base       (base_r),
    .odd        (odd_r),
    .is_special (spec_s),
    .forced     (forced_s)
  );
`else
  assign spec_s   = 1'b0;
  assign forced_s = FP_ONE;
`endif

  // MUL multiplies the accumulator by the running square; SQ squares it.
  always_comb begin
    if (state_r == MUL) begin
      mult_a_s = acc_r;
    end else begin
      mult_a_s = sq_r;
    end
  end

  ieee_754_multiplier u_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (mult_start_r),
    .a      (mult_a_s),
    .b      (sq_r),
    .result (mult_res_s),
    .valid  (mult_valid_s),
    .busy   (mult_busy_s)
  );

  assign bus.result = result_r;
  assign bus.valid  = valid_r;
  assign bus.busy   = busy_r;

  // Control FSM: CHECK registers its decision in phase 0 and acts in phase 1;
  // MUL/SQ issue a one-cycle multiplier start in phase 0 and wait in phase 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      acc_r        <= 32'h0;
      sq_r         <= 32'h0;
      e_rem_r      <= {EXP_W{1'b0}};
      result_r     <= 32'h0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      ph_r         <= 1'b0;
      mult_start_r <= 1'b0;
      dec_zero_r   <= 1'b0;
      dec_spec_r   <= 1'b0;
      dec_forced_r <= 32'h0;
`ifdef FP_POW_SPECIAL_EN
      base_r       <= 32'h0;
      odd_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          // A start coinciding with the valid pulse is dropped.
          if (bus.start && !valid_r) begin
            acc_r   <= FP_ONE;
            sq_r    <= bus.use_e ? FP_E : bus.base;
            e_rem_r <= bus.exp;
            busy_r  <= 1'b1;
            ph_r    <= 1'b0;
            state_r <= CHECK;
`ifdef FP_POW_SPECIAL_EN
            base_r  <= bus.use_e ? FP_E : bus.base;
            odd_r   <= bus.exp[0];
`endif
          end
        end
        CHECK: begin
          if (!ph_r) begin
            dec_zero_r   <= (e_rem_r == {EXP_W{1'b0}});
            dec_spec_r   <= spec_s;
            dec_forced_r <= forced_s;
            ph_r         <= 1'b1;
          end else begin
            ph_r <= 1'b0;
            if (dec_zero_r) begin
              state_r <= DONE;
            end else if (dec_spec_r) begin
              acc_r   <= dec_forced_r;
              state_r <= DONE;
            end else if (e_rem_r[0]) begin
              state_r <= MUL;
            end else begin
              state_r <= SQ;
            end
          end
        end
        MUL: begin
          if (!ph_r) begin
            if (!mult_busy_s) begin
              mult_start_r <= 1'b1;
              ph_r         <= 1'b1;
            end
          end else begin
            mult_start_r <= 1'b0;
            if (mult_valid_s) begin
              acc_r <= mult_res_s;
              ph_r  <= 1'b0;
              // No squaring is needed once the top exponent bit is consumed.
              if ((e_rem_r >> 1'b1) == {EXP_W{1'b0}}) begin
                state_r <= DONE;
              end else begin
                state_r <= SQ;
              end
            end
          end
        end
        SQ: begin
          if (!ph_r) begin
            if (!mult_busy_s) begin
              mult_start_r <= 1'b1;
              ph_r         <= 1'b1;
            end
          end else begin
            mult_start_r <= 1'b0;
            if (mult_valid_s) begin
              sq_r    <= mult_res_s;
              e_rem_r <= e_rem_r >> 1'b1;
              ph_r    <= 1'b0;
              state_r <= CHECK;
            end
          end
        end
        DONE: begin
          result_r <= acc_r;
          valid_r  <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_int_power.sv
// Directed self-checking bench for fp_int_power (EXP_W = 16).
module tb_fp_int_power;
  import fp_pow_pkg::*;

  logic clk;
  logic rst;
  int   total_cnt;
  int   bad_cnt;
  int   mcount;

  fp_int_power_if #(.EXP_W(16)) bus ();

  fp_int_power #(.EXP_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count multiplier start pulses issued by the FSM.
  always @(posedge clk) begin
    if (dut.mult_start_r) mcount <= mcount + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total_cnt++;
    if (obs !== want) begin
      bad_cnt++;
      $display("FAIL %s: got=%h want=%h", tag, obs, want);
    end
  endtask

  // One operation; want_lat < 0 skips the latency check. poke pulses start
  // while busy and again during the valid cycle, both must be ignored.
  task automatic run_op(input string tag, input logic ue, input logic [31:0] b,
                        input logic [15:0] x, input logic [31:0] want,
                        input int want_lat, input int want_mul, input logic poke);
    int lat;
    int m0;
    @(negedge clk);
    m0 = mcount;
    bus.start = 1'b1; bus.use_e = ue; bus.base = b; bus.exp = x;
    @(negedge clk);
    bus.start = 1'b0; bus.use_e = 1'b0; bus.base = 32'h0; bus.exp = 16'h0;
    check_val({tag, "/busy_acc"}, {31'h0, bus.busy}, 32'd1);
    lat = 0;
    while (!bus.valid && lat < 3000) begin
      if (poke && lat == 1) begin
        bus.start = 1'b1; bus.use_e = 1'b1; bus.exp = 16'h0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check_val({tag, "/valid"}, {31'h0, bus.valid}, 32'd1);
    if (want_lat >= 0) check_val({tag, "/lat"}, lat, want_lat);
    check_val({tag, "/result"}, bus.result, want);
    check_val({tag, "/busy_at_valid"}, {31'h0, bus.busy}, 32'd0);
    if (poke) begin
      bus.start = 1'b1; bus.use_e = 1'b1; bus.exp = 16'h0;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.use_e = 1'b0;
    check_val({tag, "/valid_drop"}, {31'h0, bus.valid}, 32'd0);
    check_val({tag, "/busy_after"}, {31'h0, bus.busy}, 32'd0);
    check_val({tag, "/hold"}, bus.result, want);
    check_val({tag, "/mults"}, mcount - m0, want_mul);
  endtask

  initial begin
    int n;
    int vcnt;
    total_cnt = 0; bad_cnt = 0; mcount = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.use_e = 1'b0; bus.base = 32'h0; bus.exp = 16'h0;
    repeat (2) @(negedge clk);
    check_val("rst/result", bus.result, 32'h0);
    check_val("rst/valid", {31'h0, bus.valid}, 32'd0);
    check_val("rst/busy", {31'h0, bus.busy}, 32'd0);
    rst = 1'b0;

    run_op("e_pow0",   1'b1, 32'h0,         16'd0,  32'h3F80_0000, 3, 0, 1'b0);
    run_op("nan_pow0", 1'b0, 32'h7FC0_0000, 16'd0,  32'h3F80_0000, 3, 0, 1'b0);
    run_op("e_pow1",   1'b1, 32'h0,         16'd1,  32'h402D_F854, -1, 1, 1'b0);
    run_op("two_p10",  1'b0, 32'h4000_0000, 16'd10, 32'h4480_0000, -1, 5, 1'b0);
    run_op("m2_p3",    1'b0, 32'hC000_0000, 16'd3,  32'hC100_0000, -1, 3, 1'b0);
    run_op("half_p4",  1'b0, 32'h3F00_0000, 16'd4,  32'h3D80_0000, -1, 3, 1'b0);
    run_op("poke_p10", 1'b0, 32'h4000_0000, 16'd10, 32'h4480_0000, -1, 5, 1'b1);

`ifdef FP_POW_SPECIAL_EN
    run_op("sp_nan",  1'b0, 32'h7FC0_0000, 16'd5, 32'h7FC0_0000, 3, 0, 1'b0);
    run_op("sp_m1",   1'b0, 32'hBF80_0000, 16'd7, 32'hBF80_0000, 3, 0, 1'b0);
    run_op("sp_mz",   1'b0, 32'h8000_0000, 16'd2, 32'h0000_0000, 3, 0, 1'b0);
    run_op("sp_minf", 1'b0, 32'hFF80_0000, 16'd3, 32'hFF80_0000, 3, 0, 1'b0);
`endif

    // Abort in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.use_e = 1'b0; bus.base = 32'h4000_0000; bus.exp = 16'd10;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (dut.state_r != MUL && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("abort/reach_mul", {31'h0, (dut.state_r == MUL)}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort/result", bus.result, 32'h0);
    check_val("abort/valid", {31'h0, bus.valid}, 32'd0);
    check_val("abort/busy", {31'h0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid) vcnt++;
    end
    check_val("abort/no_valid", vcnt, 32'd0);
    run_op("after_rst", 1'b0, 32'h4000_0000, 16'd2, 32'h4080_0000, -1, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
